// File: rtl/st7789_seq.sv
// ----------------------------------------------------------------------------
// st7789_seq
//
// Power-up sequencer and SPI-mode-3 byte serializer for an ST7789 panel.
// After reset it pulses the panel reset pin, waits, and streams a fixed
// five-entry init list. It then accepts command/data bytes from the CPU over
// a valid/ready handshake and shifts each one out MSB first. It is the sole
// driver of the four panel pins; every output comes straight from a flop.
//
// Parameters:
//   CLK_DIV    - clk cycles per SCL half-period (>= 1)
//   RES_CYCLES - clk cycles st7789_RES is held low after reset (>= 1, < 2^24)
//   INIT_WAIT  - delay after RES release and after "wait" entries (>= 1, < 2^24)
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   cmd_valid     - a byte is offered
//   cmd_ready     - byte accepted this cycle (high only in IDLE)
//   cmd_dc        - 0 = command byte, 1 = data byte
//   cmd_data      - byte to send
//   init_done     - init list fully sent; sticky until reset
//   busy          - high in every state except IDLE
//   st7789_SDA    - serial data, MSB first
//   st7789_SCL    - serial clock, idles high
//   st7789_DC     - data/command select, held until the next byte starts
//   st7789_RES    - panel reset, active low
// ----------------------------------------------------------------------------
module st7789_seq #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned RES_CYCLES = 1000,
    parameter int unsigned INIT_WAIT  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dc,
    input  logic [7:0] cmd_data,
    output logic       init_done,
    output logic       busy,
    output logic       st7789_SDA,
    output logic       st7789_SCL,
    output logic       st7789_DC,
    output logic       st7789_RES
);

    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_INIT_SEND,
        ST_INIT_DLY,
        ST_IDLE,
        ST_SHIFT
    } state_t;

    localparam logic [23:0] DIV_LD  = 24'(CLK_DIV);
    localparam logic [23:0] RES_LD  = 24'(RES_CYCLES);
    localparam logic [23:0] WAIT_LD = 24'(INIT_WAIT);
    localparam logic [2:0]  LAST_ENTRY = 3'd4;

    // Init list entry packed as {dc, byte, wait}.
    function automatic logic [9:0] init_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    init_entry = {1'b0, 8'h01, 1'b1};  // SWRESET
            3'd1:    init_entry = {1'b0, 8'h11, 1'b1};  // SLPOUT
            3'd2:    init_entry = {1'b0, 8'h3A, 1'b0};  // COLMOD
            3'd3:    init_entry = {1'b1, 8'h55, 1'b0};  // 16 bpp
            3'd4:    init_entry = {1'b0, 8'h29, 1'b0};  // DISPON
            default: init_entry = '0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [23:0] cnt_q,   cnt_d;     // shared delay / half-period counter
    logic [2:0]  bit_q,   bit_d;     // bits still to send after the current one
    logic [7:0]  shreg_q, shreg_d;   // remaining bits, next one in [7]
    logic [2:0]  idx_q,   idx_d;     // init list index
    logic        wait_q,  wait_d;    // current init entry has a trailing delay
    logic        scl_q,   scl_d;
    logic        sda_q,   sda_d;
    logic        dc_q,    dc_d;
    logic        res_q,   res_d;
    logic        ready_q, ready_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    logic        byte_done;
    logic        start_byte;
    logic        start_dc;
    logic [7:0]  start_val;
    logic        init_load;
    logic [2:0]  init_sel;
    logic [9:0]  entry;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        scl_d      = scl_q;
        sda_d      = sda_q;
        dc_d       = dc_q;
        res_d      = res_q;
        done_d     = done_q;
        byte_done  = 1'b0;
        start_byte = 1'b0;
        start_dc   = 1'b0;
        start_val  = '0;
        init_load  = 1'b0;
        init_sel   = '0;
        entry      = '0;

        // Bit engine shared by the init stream and CPU bytes. Entry into a
        // byte already drove the first low phase, so here we only time phases.
        if (state_q == ST_INIT_SEND || state_q == ST_SHIFT) begin
            if (cnt_q > 24'd1) begin
                cnt_d = cnt_q - 24'd1;
            end else if (!scl_q) begin
                scl_d = 1'b1;
                cnt_d = DIV_LD;
            end else if (bit_q != 3'd0) begin
                scl_d   = 1'b0;
                sda_d   = shreg_q[7];
                shreg_d = {shreg_q[6:0], 1'b0};
                bit_d   = bit_q - 3'd1;
                cnt_d   = DIV_LD;
            end else begin
                byte_done = 1'b1;  // SCL stays high, SDA keeps its last value
            end
        end

        case (state_q)
            ST_RST_LOW: begin
                // Counter is zero straight out of reset; the first cycle loads it.
                if (cnt_q == 24'd0) begin
                    cnt_d = RES_LD;
                end else if (cnt_q == 24'd1) begin
                    state_d = ST_RST_WAIT;
                    cnt_d   = WAIT_LD;
                    res_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_q <= 24'd1) begin
                    init_load = 1'b1;
                    init_sel  = 3'd0;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            ST_INIT_SEND: begin
                if (byte_done) begin
                    if (idx_q == LAST_ENTRY) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (wait_q) begin
                        state_d = ST_INIT_DLY;
                        cnt_d   = WAIT_LD;
                        idx_d   = idx_q + 3'd1;
                    end else begin
                        init_load = 1'b1;
                        init_sel  = idx_q + 3'd1;
                    end
                end
            end
            ST_INIT_DLY: begin
                if (cnt_q <= 24'd1) begin
                    init_load = 1'b1;
                    init_sel  = idx_q;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    state_d    = ST_SHIFT;
                    start_byte = 1'b1;
                    start_dc   = cmd_dc;
                    start_val  = cmd_data;
                end
            end
            ST_SHIFT: begin
                if (byte_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_RST_LOW;
        endcase

        if (init_load) begin
            entry      = init_entry(init_sel);
            state_d    = ST_INIT_SEND;
            idx_d      = init_sel;
            wait_d     = entry[0];
            start_byte = 1'b1;
            start_dc   = entry[9];
            start_val  = entry[8:1];
        end

        // Starting a byte drops SCL and presents DC and the MSB in the same cycle.
        if (start_byte) begin
            scl_d   = 1'b0;
            sda_d   = start_val[7];
            shreg_d = {start_val[6:0], 1'b0};
            dc_d    = start_dc;
            bit_d   = 3'd7;
            cnt_d   = DIV_LD;
        end

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST_LOW;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            idx_q   <= '0;
            wait_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b0;
            dc_q    <= 1'b0;
            res_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            dc_q    <= dc_d;
            res_q   <= res_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign init_done  = done_q;
    assign st7789_SCL = scl_q;
    assign st7789_SDA = sda_q;
    assign st7789_DC  = dc_q;
    assign st7789_RES = res_q;

endmodule

// File: tb/tb_st7789_seq.sv
// ----------------------------------------------------------------------------
// tb_st7789_seq
//
// Bench for st7789_seq with CLK_DIV=2, RES_CYCLES=8, INIT_WAIT=16. A pin
// monitor rebuilds transmitted bytes from SDA at each SCL rise and checks
// phase lengths and signal stability; the tests compare the rebuilt stream and
// handshake timing against expectations derived from the byte-level rules.
// ----------------------------------------------------------------------------
module tb_st7789_seq;

    localparam int D = 2;
    localparam int R = 8;
    localparam int W = 16;
    localparam int BYTE_PERIOD = 16 * D + 1;

    typedef struct {
        logic       dc;
        logic [7:0] data;
        int         first_fall;
        int         last_rise;
    } byte_rec_t;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dc;
    logic [7:0] cmd_data;
    logic       init_done;
    logic       busy;
    logic       st7789_SDA;
    logic       st7789_SCL;
    logic       st7789_DC;
    logic       st7789_RES;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel0 = 0;
    int mon_phase_err = 0;
    int mon_sig_err = 0;

    byte_rec_t  mon_q[$];
    logic [8:0] exp_q[$];

    st7789_seq #(
        .CLK_DIV   (D),
        .RES_CYCLES(R),
        .INIT_WAIT (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dc    (cmd_dc),
        .cmd_data  (cmd_data),
        .init_done (init_done),
        .busy      (busy),
        .st7789_SDA(st7789_SDA),
        .st7789_SCL(st7789_SCL),
        .st7789_DC (st7789_DC),
        .st7789_RES(st7789_RES)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pin monitor: samples at negedge, away from the active edge.
    initial begin : monitor
        int         bitn;
        int         run;
        logic       prev_scl, prev_sda, prev_dc, fell, cur_dc;
        logic [7:0] cur_byte;
        int         cur_first;
        byte_rec_t  rec;
        bitn = 0; run = 0; prev_scl = 1'b1; prev_sda = 1'b0; prev_dc = 1'b0;
        cur_dc = 1'b0; cur_byte = '0; cur_first = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bitn = 0; run = 0; prev_scl = 1'b1; prev_sda = 1'b0; prev_dc = 1'b0;
            end else begin
                fell = prev_scl && !st7789_SCL;
                if (st7789_SCL !== prev_scl) begin
                    if (fell) begin
                        if (bitn != 0 && run != D) mon_phase_err++;
                        if (bitn == 0) cur_first = cyc;
                    end else begin
                        if (run != D) mon_phase_err++;
                        if (bitn == 0) cur_dc = st7789_DC;
                        else if (st7789_DC !== cur_dc) mon_sig_err++;
                        cur_byte = {cur_byte[6:0], st7789_SDA};
                        bitn++;
                        if (bitn == 8) begin
                            rec.dc = cur_dc; rec.data = cur_byte;
                            rec.first_fall = cur_first; rec.last_rise = cyc;
                            mon_q.push_back(rec);
                            bitn = 0;
                        end
                    end
                    run = 1;
                end else begin
                    run++;
                end
                // SDA and DC may only move on the cycle SCL falls.
                if (!fell && (st7789_SDA !== prev_sda || st7789_DC !== prev_dc)) mon_sig_err++;
                prev_scl = st7789_SCL; prev_sda = st7789_SDA; prev_dc = st7789_DC;
            end
        end
    end

    task automatic wait_ready(output int n);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Offers a byte and returns on the negedge right after the accepting edge.
    task automatic do_handshake(input logic d, input logic [7:0] v, output int hs);
        int n;
        cmd_valid = 1'b1; cmd_dc = d; cmd_data = v;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        hs = cyc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n_low, n_hi;
        rst_n = 1'b0; cmd_valid = 1'b0;
        mon_q.delete(); exp_q.delete();
        repeat (3) @(negedge clk);
        checks++;
        if ({st7789_RES, st7789_SCL, st7789_SDA, st7789_DC, cmd_ready, busy, init_done} !== 7'b0100010) begin
            errors++;
            $display("FAIL reset_values: {res,scl,sda,dc,ready,busy,done}=%b required 0100010",
                     {st7789_RES, st7789_SCL, st7789_SDA, st7789_DC, cmd_ready, busy, init_done});
        end
        rst_n = 1'b1;
        n_low = 0;
        @(negedge clk);
        rel0 = cyc;
        while (st7789_RES === 1'b0 && n_low < 1000) begin
            n_low++;
            @(negedge clk);
        end
        checks++;
        if (n_low != R) begin
            errors++;
            $display("FAIL res_low_cycles: got %0d required %0d", n_low, R);
        end
        n_hi = 0;
        while (st7789_SCL === 1'b1 && st7789_RES === 1'b1 && n_hi < 1000) begin
            n_hi++;
            @(negedge clk);
        end
        checks++;
        if (n_hi != W || st7789_SCL !== 1'b0 || st7789_RES !== 1'b1) begin
            errors++;
            $display("FAIL res_wait_cycles: got %0d scl=%b res=%b required %0d scl=0 res=1",
                     n_hi, st7789_SCL, st7789_RES, W);
        end
    endtask

    task automatic test_init();
        int n, early;
        logic [8:0] init_exp [5];
        init_exp = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h029};
        foreach (init_exp[i]) exp_q.push_back(init_exp[i]);
        // A request offered during init must be ignored and never sent.
        cmd_valid = 1'b1; cmd_dc = 1'b1; cmd_data = 8'h77;
        n = 0; early = 0;
        while (init_done !== 1'b1 && n < 5000) begin
            if (cmd_ready !== 1'b0) early++;
            @(negedge clk);
            n++;
            if (n == 100) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL init_ready_early: cmd_ready high in %0d init cycles, required 0", early);
        end
        checks++;
        if (init_done !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL init_done_ready: done=%b ready=%b required 1 1", init_done, cmd_ready);
        end
        checks++;
        if (cyc - rel0 != R + 3 * W + 80 * D) begin
            errors++;
            $display("FAIL init_done_time: got %0d required %0d", cyc - rel0, R + 3 * W + 80 * D);
        end
        checks++;
        if (mon_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL init_count: got %0d bytes required %0d", mon_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            checks++;
            if ({mon_q[i].dc, mon_q[i].data} !== exp_q[i]) begin
                errors++;
                $display("FAIL init_byte%0d: got dc=%b %02h required dc=%b %02h",
                         i, mon_q[i].dc, mon_q[i].data, exp_q[i][8], exp_q[i][7:0]);
            end
        end
        if (mon_q.size() >= 3) begin
            checks++;
            if (mon_q[0].first_fall - rel0 != R + W) begin
                errors++;
                $display("FAIL init_first_fall: got %0d required %0d", mon_q[0].first_fall - rel0, R + W);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (mon_q[i + 1].first_fall - (mon_q[i].last_rise + D) < W) begin
                    errors++;
                    $display("FAIL init_gap%0d: got %0d required >= %0d",
                             i, mon_q[i + 1].first_fall - (mon_q[i].last_rise + D), W);
                end
            end
        end
        mon_q.delete(); exp_q.delete();
    endtask

    task automatic test_single();
        int hs, n, pe, se;
        pe = mon_phase_err; se = mon_sig_err;
        do_handshake(1'b1, 8'hA5, hs);
        cmd_valid = 1'b0;
        checks++;
        if ({st7789_SCL, st7789_DC, st7789_SDA} !== 3'b011) begin
            errors++;
            $display("FAIL single_first_bit: {scl,dc,sda}=%b required 011", {st7789_SCL, st7789_DC, st7789_SDA});
        end
        wait_ready(n);
        checks++;
        if (1 + n != BYTE_PERIOD) begin
            errors++;
            $display("FAIL single_ready_latency: got %0d required %0d", 1 + n, BYTE_PERIOD);
        end
        checks++;
        if (mon_q.size() != 1 || mon_q[0].dc !== 1'b1 || mon_q[0].data !== 8'hA5) begin
            errors++;
            $display("FAIL single_byte: got %0d bytes first=%02h required 1 byte dc=1 a5",
                     mon_q.size(), (mon_q.size() > 0) ? mon_q[0].data : 8'h00);
        end
        checks++;
        if (mon_phase_err != pe || mon_sig_err != se) begin
            errors++;
            $display("FAIL single_waveform: phase errors %0d signal errors %0d required 0 0",
                     mon_phase_err - pe, mon_sig_err - se);
        end
        mon_q.delete();
    endtask

    task automatic test_back_to_back();
        int h1, h2, n, se;
        se = mon_sig_err;
        do_handshake(1'b0, 8'h2C, h1);
        do_handshake(1'b1, 8'hFF, h2);
        cmd_valid = 1'b0;
        checks++;
        if (h2 - h1 != BYTE_PERIOD) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d required %0d", h2 - h1, BYTE_PERIOD);
        end
        wait_ready(n);
        checks++;
        if (mon_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d required 2", mon_q.size());
        end else begin
            checks++;
            if ({mon_q[0].dc, mon_q[0].data, mon_q[1].dc, mon_q[1].data} !== {1'b0, 8'h2C, 1'b1, 8'hFF}) begin
                errors++;
                $display("FAIL b2b_bytes: got %b/%02h %b/%02h required 0/2c 1/ff",
                         mon_q[0].dc, mon_q[0].data, mon_q[1].dc, mon_q[1].data);
            end
            checks++;
            if (mon_q[1].first_fall != h2 + 1) begin
                errors++;
                $display("FAIL b2b_second_fall: got %0d required %0d", mon_q[1].first_fall, h2 + 1);
            end
        end
        checks++;
        if (mon_sig_err != se) begin
            errors++;
            $display("FAIL b2b_dc_stable: %0d DC/SDA moves off an SCL fall, required 0", mon_sig_err - se);
        end
        mon_q.delete();
    endtask

    task automatic test_ignore();
        int hs, n, hi;
        do_handshake(1'b0, 8'h3C, hs);
        cmd_valid = 1'b1; cmd_dc = 1'b1; cmd_data = 8'h77;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready !== 1'b0 || busy !== 1'b1) hi++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL ignore_ready: ready/busy wrong in %0d shift cycles, required 0", hi);
        end
        wait_ready(n);
        repeat (4) @(negedge clk);
        checks++;
        if (mon_q.size() != 1 || mon_q[0].data !== 8'h3C || mon_q[0].dc !== 1'b0) begin
            errors++;
            $display("FAIL ignore_stream: got %0d bytes first=%02h required 1 byte 3c",
                     mon_q.size(), (mon_q.size() > 0) ? mon_q[0].data : 8'h00);
        end
        mon_q.delete();
    endtask

    task automatic test_random();
        int h_prev, h, g, n, pe, se;
        logic d;
        logic [7:0] v;
        pe = mon_phase_err; se = mon_sig_err;
        h_prev = 0;
        for (int i = 0; i < 16; i++) begin
            d = 1'($urandom_range(0, 1));
            v = 8'($urandom_range(0, 255));
            g = (i == 0) ? 0 : int'($urandom_range(0, 3));
            if (g > 0) begin
                cmd_valid = 1'b0;
                wait_ready(n);
                repeat (g) @(negedge clk);
            end
            do_handshake(d, v, h);
            exp_q.push_back({d, v});
            if (i > 0) begin
                checks++;
                if (h - h_prev != BYTE_PERIOD + g) begin
                    errors++;
                    $display("FAIL rand_spacing%0d: got %0d required %0d", i, h - h_prev, BYTE_PERIOD + g);
                end
            end
            h_prev = h;
        end
        cmd_valid = 1'b0;
        wait_ready(n);
        checks++;
        if (mon_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d required %0d", mon_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            checks++;
            if ({mon_q[i].dc, mon_q[i].data} !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_byte%0d: got dc=%b %02h required dc=%b %02h",
                         i, mon_q[i].dc, mon_q[i].data, exp_q[i][8], exp_q[i][7:0]);
            end
        end
        checks++;
        if (mon_phase_err != pe || mon_sig_err != se) begin
            errors++;
            $display("FAIL rand_waveform: phase errors %0d signal errors %0d required 0 0",
                     mon_phase_err - pe, mon_sig_err - se);
        end
        mon_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int hs;
        do_handshake(1'b1, 8'h96, hs);
        cmd_valid = 1'b0;
        // Advance into the low phase of the third bit.
        repeat (4 * D) @(negedge clk);
        checks++;
        if (st7789_SCL !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: scl=%b busy=%b required 0 1", st7789_SCL, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({st7789_SCL, st7789_RES, busy, init_done, cmd_ready, st7789_DC} !== 6'b101000) begin
            errors++;
            $display("FAIL midreset_abort: {scl,res,busy,done,ready,dc}=%b required 101000",
                     {st7789_SCL, st7789_RES, busy, init_done, cmd_ready, st7789_DC});
        end
        @(negedge clk);
        test_reset();
        test_init();
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_dc = 1'b0; cmd_data = 8'h00;
        test_reset();
        test_init();
        test_single();
        test_back_to_back();
        test_ignore();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
